// File: rtl/ili9341_pkg.sv
// Shared definitions for the ILI9341 parallel-bus decoder: panel geometry
// defaults, command codes, reset values of the parameter registers, the
// decoder state type and the window range check.
package ili9341_pkg;

  localparam int DEF_COLS = 320;
  localparam int DEF_ROWS = 240;

  localparam logic [7:0] CMD_SWRESET = 8'h01;
  localparam logic [7:0] CMD_SLPIN   = 8'h10;
  localparam logic [7:0] CMD_SLPOUT  = 8'h11;
  localparam logic [7:0] CMD_DISPOFF = 8'h28;
  localparam logic [7:0] CMD_DISPON  = 8'h29;
  localparam logic [7:0] CMD_CASET   = 8'h2A;
  localparam logic [7:0] CMD_PASET   = 8'h2B;
  localparam logic [7:0] CMD_RAMWR   = 8'h2C;
  localparam logic [7:0] CMD_MADCTL  = 8'h36;
  localparam logic [7:0] CMD_COLMOD  = 8'h3A;

  localparam logic [7:0] MADCTL_RST = 8'h00;
  localparam logic [7:0] PIXFMT_RST = 8'h66;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CASET,
    ST_PASET,
    ST_RAMWR_HI,
    ST_RAMWR_LO,
    ST_PARAM1,
    ST_SKIP
  } dec_state_t;

  // A window is usable when it is not inverted and its end lies on the panel.
  function automatic logic window_ok(input logic [15:0] i_start,
                                     input logic [15:0] i_end,
                                     input int          i_limit);
    return (i_start <= i_end) && (int'({16'h0000, i_end}) < i_limit);
  endfunction

endpackage

// File: rtl/ili9341_window_ctr.sv
// Column/page window registers (SC/EC/SP/EP) and the pixel write cursor.
// Window updates are validated as a whole; a rejected update leaves the
// old window in place and raises o_win_err for one cycle.
import ili9341_pkg::*;

module ili9341_window_ctr #(
  parameter int COLS = DEF_COLS,
  parameter int ROWS = DEF_ROWS
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_clear,
  input  logic        i_col_wr,
  input  logic        i_row_wr,
  input  logic [15:0] i_start,
  input  logic [15:0] i_end,
  input  logic        i_home,
  input  logic        i_advance,
  output logic [8:0]  o_x,
  output logic [8:0]  o_y,
  output logic        o_win_err
);

  localparam logic [8:0] EC_RST = 9'(COLS - 1);
  localparam logic [8:0] EP_RST = 9'(ROWS - 1);

  logic [8:0] r_sc;
  logic [8:0] r_ec;
  logic [8:0] r_sp;
  logic [8:0] r_ep;
  logic [8:0] r_x;
  logic [8:0] r_y;
  logic       r_win_err;
  logic       w_col_ok;
  logic       w_row_ok;

  assign w_col_ok  = window_ok(i_start, i_end, COLS);
  assign w_row_ok  = window_ok(i_start, i_end, ROWS);
  assign o_x       = r_x;
  assign o_y       = r_y;
  assign o_win_err = r_win_err;

  // Window registers, rejection pulse and raster-order cursor with wrap.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_sc      <= 9'd0;
      r_ec      <= EC_RST;
      r_sp      <= 9'd0;
      r_ep      <= EP_RST;
      r_x       <= 9'd0;
      r_y       <= 9'd0;
      r_win_err <= 1'b0;
    end else if (i_clear) begin
      r_sc      <= 9'd0;
      r_ec      <= EC_RST;
      r_sp      <= 9'd0;
      r_ep      <= EP_RST;
      r_x       <= 9'd0;
      r_y       <= 9'd0;
      r_win_err <= 1'b0;
    end else begin
      r_win_err <= 1'b0;
      if (i_col_wr) begin
        if (w_col_ok) begin
          r_sc <= i_start[8:0];
          r_ec <= i_end[8:0];
        end else begin
          r_win_err <= 1'b1;
        end
      end
      if (i_row_wr) begin
        if (w_row_ok) begin
          r_sp <= i_start[8:0];
          r_ep <= i_end[8:0];
        end else begin
          r_win_err <= 1'b1;
        end
      end
      if (i_home) begin
        r_x <= r_sc;
        r_y <= r_sp;
      end else if (i_advance) begin
        if (r_x < r_ec) begin
          r_x <= r_x + 9'd1;
        end else begin
          r_x <= r_sc;
          if (r_y < r_ep) begin
            r_y <= r_y + 9'd1;
          end else begin
            r_y <= r_sp;
          end
        end
      end
    end
  end

endmodule

// File: rtl/ili9341_bus_decoder.sv
// ILI9341 8-bit parallel bus decoder: captures bytes on the rising edge of
// the write strobe, interprets the command set needed for pixel streaming
// and emits one addressed 16-bit pixel per two RAMWR data bytes.
// Optional feature macro: ILI9341_DEC_STATS_EN adds saturating pix_count and
// drop_count outputs; without it those ports and counters do not exist.
import ili9341_pkg::*;

module ili9341_bus_decoder #(
  parameter int COLS = DEF_COLS,
  parameter int ROWS = DEF_ROWS
) (
  input  logic        clk_16MHz,
  input  logic        reset,
  input  logic        nreset,
  input  logic        cmd_data,
  input  logic        write_edge,
  input  logic [7:0]  din,
  output logic        pix_valid,
  output logic [8:0]  pix_x,
  output logic [8:0]  pix_y,
  output logic [15:0] pix_data,
  output logic        display_on,
  output logic        sleep_out,
  output logic [7:0]  madctl,
  output logic [7:0]  pixfmt,
  output logic        win_err
`ifdef ILI9341_DEC_STATS_EN
  ,
  output logic [15:0] pix_count,
  output logic [15:0] drop_count
`endif
);

  dec_state_t  r_state;
  logic        r_we_d;
  logic [1:0]  r_cnt;
  logic [23:0] r_buf;
  logic [7:0]  r_hi;
  logic        r_param_sel;
  logic        r_pix_valid;
  logic [8:0]  r_pix_x;
  logic [8:0]  r_pix_y;
  logic [15:0] r_pix_data;
  logic        r_display_on;
  logic        r_sleep_out;
  logic [7:0]  r_madctl;
  logic [7:0]  r_pixfmt;

  logic        w_cap;
  logic        w_cmd;
  logic        w_dat;
  logic        w_swreset;
  logic        w_sync_clr;
  logic        w_col_wr;
  logic        w_row_wr;
  logic        w_home;
  logic        w_pix_done;
  logic        w_drop;
  logic [15:0] w_start;
  logic [15:0] w_end;
  logic [8:0]  w_x;
  logic [8:0]  w_y;

  assign w_cap      = write_edge & ~r_we_d & nreset;
  assign w_cmd      = w_cap & ~cmd_data;
  assign w_dat      = w_cap & cmd_data;
  assign w_swreset  = w_cmd & (din == CMD_SWRESET);
  assign w_sync_clr = ~nreset | w_swreset;
  assign w_col_wr   = w_dat & (r_state == ST_CASET) & (r_cnt == 2'd3);
  assign w_row_wr   = w_dat & (r_state == ST_PASET) & (r_cnt == 2'd3);
  assign w_home     = w_cmd & (din == CMD_RAMWR);
  assign w_pix_done = w_dat & (r_state == ST_RAMWR_LO);
  assign w_drop     = w_dat & ((r_state == ST_IDLE) | (r_state == ST_SKIP));
  assign w_start    = r_buf[23:8];
  assign w_end      = {r_buf[7:0], din};

  assign pix_valid  = r_pix_valid;
  assign pix_x      = r_pix_x;
  assign pix_y      = r_pix_y;
  assign pix_data   = r_pix_data;
  assign display_on = r_display_on;
  assign sleep_out  = r_sleep_out;
  assign madctl     = r_madctl;
  assign pixfmt     = r_pixfmt;

  ili9341_window_ctr #(
    .COLS (COLS),
    .ROWS (ROWS)
  ) u_window (
    .i_clk     (clk_16MHz),
    .i_reset   (reset),
    .i_clear   (w_sync_clr),
    .i_col_wr  (w_col_wr),
    .i_row_wr  (w_row_wr),
    .i_start   (w_start),
    .i_end     (w_end),
    .i_home    (w_home),
    .i_advance (w_pix_done),
    .o_x       (w_x),
    .o_y       (w_y),
    .o_win_err (win_err)
  );

  // Strobe history keeps following the pin during panel reset so a strobe held across nreset release is not seen as new.
  always_ff @(posedge clk_16MHz or posedge reset) begin
    if (reset) begin
      r_we_d <= 1'b0;
    end else begin
      r_we_d <= write_edge;
    end
  end

  // Command/data decoder FSM with registered pixel and status outputs.
  always_ff @(posedge clk_16MHz or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_cnt        <= 2'd0;
      r_buf        <= 24'h0;
      r_hi         <= 8'h00;
      r_param_sel  <= 1'b0;
      r_pix_valid  <= 1'b0;
      r_pix_x      <= 9'd0;
      r_pix_y      <= 9'd0;
      r_pix_data   <= 16'h0000;
      r_display_on <= 1'b0;
      r_sleep_out  <= 1'b0;
      r_madctl     <= MADCTL_RST;
      r_pixfmt     <= PIXFMT_RST;
    end else if (w_sync_clr) begin
      r_state      <= ST_IDLE;
      r_cnt        <= 2'd0;
      r_buf        <= 24'h0;
      r_hi         <= 8'h00;
      r_param_sel  <= 1'b0;
      r_pix_valid  <= 1'b0;
      r_pix_x      <= 9'd0;
      r_pix_y      <= 9'd0;
      r_pix_data   <= 16'h0000;
      r_display_on <= 1'b0;
      r_sleep_out  <= 1'b0;
      r_madctl     <= MADCTL_RST;
      r_pixfmt     <= PIXFMT_RST;
    end else begin
      r_pix_valid <= 1'b0;
      if (w_cmd) begin
        r_cnt <= 2'd0;
        case (din)
          CMD_CASET:  r_state <= ST_CASET;
          CMD_PASET:  r_state <= ST_PASET;
          CMD_RAMWR:  r_state <= ST_RAMWR_HI;
          CMD_MADCTL: begin
            r_state     <= ST_PARAM1;
            r_param_sel <= 1'b0;
          end
          CMD_COLMOD: begin
            r_state     <= ST_PARAM1;
            r_param_sel <= 1'b1;
          end
          CMD_SLPOUT: begin
            r_sleep_out <= 1'b1;
            r_state     <= ST_IDLE;
          end
          CMD_SLPIN: begin
            r_sleep_out <= 1'b0;
            r_state     <= ST_IDLE;
          end
          CMD_DISPON: begin
            r_display_on <= 1'b1;
            r_state      <= ST_IDLE;
          end
          CMD_DISPOFF: begin
            r_display_on <= 1'b0;
            r_state      <= ST_IDLE;
          end
          default:    r_state <= ST_SKIP;
        endcase
      end else if (w_dat) begin
        case (r_state)
          ST_CASET, ST_PASET: begin
            r_buf <= {r_buf[15:0], din};
            r_cnt <= r_cnt + 2'd1;
            if (r_cnt == 2'd3) begin
              r_state <= ST_IDLE;
            end
          end
          ST_RAMWR_HI: begin
            r_hi    <= din;
            r_state <= ST_RAMWR_LO;
          end
          ST_RAMWR_LO: begin
            r_pix_valid <= 1'b1;
            r_pix_x     <= w_x;
            r_pix_y     <= w_y;
            r_pix_data  <= {r_hi, din};
            r_state     <= ST_RAMWR_HI;
          end
          ST_PARAM1: begin
            if (r_param_sel) begin
              r_pixfmt <= din;
            end else begin
              r_madctl <= din;
            end
            r_state <= ST_SKIP;
          end
          default: r_state <= r_state;
        endcase
      end
    end
  end

`ifdef ILI9341_DEC_STATS_EN
  logic [15:0] r_pix_count;
  logic [15:0] r_drop_count;

  assign pix_count  = r_pix_count;
  assign drop_count = r_drop_count;

  // Saturating counters of emitted pixels and data bytes discarded in IDLE/SKIP.
  always_ff @(posedge clk_16MHz or posedge reset) begin
    if (reset) begin
      r_pix_count  <= 16'h0000;
      r_drop_count <= 16'h0000;
    end else if (w_sync_clr) begin
      r_pix_count  <= 16'h0000;
      r_drop_count <= 16'h0000;
    end else begin
      if (w_pix_done && (r_pix_count != 16'hFFFF)) begin
        r_pix_count <= r_pix_count + 16'd1;
      end
      if (w_drop && (r_drop_count != 16'hFFFF)) begin
        r_drop_count <= r_drop_count + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_ili9341_bus_decoder.sv
// Directed plus randomized bench for ili9341_bus_decoder. Expected pixel
// addresses come from a raster-index model of the active window.
`timescale 1ns/1ps

module tb_ili9341_bus_decoder;

  localparam int COLS = 320;
  localparam int ROWS = 240;

  logic        clk_16MHz = 1'b0;
  logic        reset;
  logic        nreset;
  logic        cmd_data;
  logic        write_edge;
  logic [7:0]  din;
  logic        pix_valid;
  logic [8:0]  pix_x;
  logic [8:0]  pix_y;
  logic [15:0] pix_data;
  logic        display_on;
  logic        sleep_out;
  logic [7:0]  madctl;
  logic [7:0]  pixfmt;
  logic        win_err;
`ifdef ILI9341_DEC_STATS_EN
  logic [15:0] pix_count;
  logic [15:0] drop_count;
`endif

  int checks = 0;
  int errors = 0;
  logic [33:0] pixQ[$];
  int mSc = 0;
  int mEc = COLS - 1;
  int mSp = 0;
  int mEp = ROWS - 1;

  ili9341_bus_decoder #(
    .COLS (COLS),
    .ROWS (ROWS)
  ) dut (
    .clk_16MHz  (clk_16MHz),
    .reset      (reset),
    .nreset     (nreset),
    .cmd_data   (cmd_data),
    .write_edge (write_edge),
    .din        (din),
    .pix_valid  (pix_valid),
    .pix_x      (pix_x),
    .pix_y      (pix_y),
    .pix_data   (pix_data),
    .display_on (display_on),
    .sleep_out  (sleep_out),
    .madctl     (madctl),
    .pixfmt     (pixfmt),
    .win_err    (win_err)
`ifdef ILI9341_DEC_STATS_EN
    ,
    .pix_count  (pix_count),
    .drop_count (drop_count)
`endif
  );

  always #31.25 clk_16MHz = ~clk_16MHz;

  // Record every emitted pixel as {x, y, data}.
  always @(negedge clk_16MHz) begin
    if (pix_valid === 1'b1) pixQ.push_back({pix_x, pix_y, pix_data});
  end

  initial begin
    #5ms;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic cd, input logic [7:0] d, input int hold = 1);
    @(negedge clk_16MHz);
    cmd_data   = cd;
    din        = d;
    write_edge = 1'b1;
    repeat (hold) @(negedge clk_16MHz);
    write_edge = 1'b0;
  endtask

  task automatic modelReset();
    mSc = 0; mEc = COLS - 1; mSp = 0; mEp = ROWS - 1;
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_pix_valid"}, 32'(pix_valid), 0);
    checkOutput({tag, "_pix_x"}, 32'(pix_x), 0);
    checkOutput({tag, "_pix_y"}, 32'(pix_y), 0);
    checkOutput({tag, "_pix_data"}, 32'(pix_data), 0);
    checkOutput({tag, "_display_on"}, 32'(display_on), 0);
    checkOutput({tag, "_sleep_out"}, 32'(sleep_out), 0);
    checkOutput({tag, "_madctl"}, 32'(madctl), 32'h00);
    checkOutput({tag, "_pixfmt"}, 32'(pixfmt), 32'h66);
    checkOutput({tag, "_win_err"}, 32'(win_err), 0);
  endtask

  task automatic setWindow(input bit isCol, input int s, input int e);
    logic [15:0] sv;
    logic [15:0] ev;
    bit ok;
    sv = 16'(s);
    ev = 16'(e);
    ok = (s <= e) && (e < (isCol ? COLS : ROWS));
    applyStimulus(1'b0, isCol ? 8'h2A : 8'h2B);
    applyStimulus(1'b1, sv[15:8]);
    applyStimulus(1'b1, sv[7:0]);
    applyStimulus(1'b1, ev[15:8]);
    applyStimulus(1'b1, ev[7:0]);
    checkOutput(isCol ? "caset_win_err" : "paset_win_err", 32'(win_err), 32'(!ok));
    if (ok) begin
      if (isCol) begin mSc = s; mEc = e; end
      else begin mSp = s; mEp = e; end
    end
  endtask

  task automatic runPixels(input int n, input string tag);
    logic [15:0] expData[$];
    logic [15:0] pd;
    int w, h, idx, m;
    pixQ.delete();
    applyStimulus(1'b0, 8'h2C);
    for (int k = 0; k < n; k++) begin
      pd = 16'($urandom);
      expData.push_back(pd);
      applyStimulus(1'b1, pd[15:8]);
      applyStimulus(1'b1, pd[7:0]);
    end
    repeat (2) @(negedge clk_16MHz);
    checkOutput({tag, "_count"}, 32'(pixQ.size()), 32'(n));
    w = mEc - mSc + 1;
    h = mEp - mSp + 1;
    m = (pixQ.size() < n) ? pixQ.size() : n;
    for (int k = 0; k < m; k++) begin
      idx = k % (w * h);
      checkOutput({tag, "_x"}, 32'(pixQ[k][33:25]), 32'(mSc + idx % w));
      checkOutput({tag, "_y"}, 32'(pixQ[k][24:16]), 32'(mSp + idx / w));
      checkOutput({tag, "_data"}, 32'(pixQ[k][15:0]), 32'(expData[k]));
    end
  endtask

  initial begin
    int cs, ce, rs, re;
    logic [7:0] rnd;
    reset = 1'b1; nreset = 1'b1; cmd_data = 1'b0; write_edge = 1'b0; din = 8'h00;
    repeat (3) @(negedge clk_16MHz);
    reset = 1'b0;
    checkResetValues("reset");

    // First pixel after RAMWR with latency of one cycle.
    pixQ.delete();
    applyStimulus(1'b0, 8'h2C);
    applyStimulus(1'b1, 8'hF8);
    checkOutput("hi_only_no_pix", 32'(pix_valid), 0);
    applyStimulus(1'b1, 8'h1F);
    checkOutput("first_pix_valid", 32'(pix_valid), 1);
    checkOutput("first_pix_data", 32'(pix_data), 32'hF81F);
    checkOutput("first_pix_x", 32'(pix_x), 0);
    checkOutput("first_pix_y", 32'(pix_y), 0);

    // Small window with wrap back to the origin.
    setWindow(1'b1, 10, 11);
    setWindow(1'b0, 5, 5);
    runPixels(4, "wrap2x1");

    // Flags and parameters, then soft reset restores everything.
    applyStimulus(1'b0, 8'h29);
    applyStimulus(1'b0, 8'h11);
    checkOutput("display_on_set", 32'(display_on), 1);
    checkOutput("sleep_out_set", 32'(sleep_out), 1);
    rnd = 8'($urandom);
    applyStimulus(1'b0, 8'h36);
    applyStimulus(1'b1, rnd);
    applyStimulus(1'b1, ~rnd);
    checkOutput("madctl_first_byte", 32'(madctl), 32'(rnd));
    applyStimulus(1'b0, 8'h3A);
    applyStimulus(1'b1, 8'h55);
    checkOutput("pixfmt_set", 32'(pixfmt), 32'h55);
    applyStimulus(1'b0, 8'h10);
    applyStimulus(1'b0, 8'h28);
    checkOutput("sleep_out_clr", 32'(sleep_out), 0);
    checkOutput("display_on_clr", 32'(display_on), 0);
    applyStimulus(1'b0, 8'h29);
    applyStimulus(1'b0, 8'h01);
    modelReset();
    checkResetValues("swreset");

    // Rejected inverted window keeps full-width window; cross a row boundary.
    setWindow(1'b1, 16, 5);
    runPixels(COLS + 5, "full_row");

    // Partial CASET discarded by a following command.
    applyStimulus(1'b0, 8'h2A);
    applyStimulus(1'b1, 8'h00);
    applyStimulus(1'b1, 8'h10);
    applyStimulus(1'b0, 8'h29);
    checkOutput("dispon_after_partial", 32'(display_on), 1);
    runPixels(3, "after_partial");

    // A strobe held high for five cycles captures exactly one byte.
    pixQ.delete();
    applyStimulus(1'b0, 8'h2C);
    applyStimulus(1'b1, 8'hA5, 5);
    repeat (2) @(negedge clk_16MHz);
    checkOutput("held_strobe_no_pix", 32'(pixQ.size()), 0);
    applyStimulus(1'b1, 8'h3C);
    repeat (2) @(negedge clk_16MHz);
    checkOutput("held_strobe_count", 32'(pixQ.size()), 1);
    if (pixQ.size() > 0) checkOutput("held_strobe_data", 32'(pixQ[0][15:0]), 32'hA53C);

    // End beyond the panel is rejected for both axes.
    setWindow(1'b1, 0, COLS);
    setWindow(1'b0, 3, ROWS);

    // Randomized windows (some invalid) with random pixel bursts.
    for (int it = 0; it < 8; it++) begin
      cs = $urandom_range(0, COLS + 10);
      ce = (it % 2 == 0) ? cs + $urandom_range(0, 3) : $urandom_range(0, COLS + 10);
      rs = $urandom_range(0, ROWS + 10);
      re = (it % 2 == 0) ? rs + $urandom_range(0, 2) : $urandom_range(0, ROWS + 10);
      setWindow(1'b1, cs, ce);
      setWindow(1'b0, rs, re);
      runPixels($urandom_range(1, 24), "random");
    end

    // Panel reset clears state and ignores captures while low.
    applyStimulus(1'b0, 8'h11);
    @(negedge clk_16MHz);
    nreset = 1'b0;
    applyStimulus(1'b0, 8'h29);
    applyStimulus(1'b0, 8'h36);
    applyStimulus(1'b1, 8'h77);
    nreset = 1'b1;
    modelReset();
    @(negedge clk_16MHz);
    checkResetValues("nreset");
    runPixels(2, "post_nreset");

    // Reset mid-pixel drops the held high byte.
    applyStimulus(1'b0, 8'h2C);
    applyStimulus(1'b1, 8'h12);
    pixQ.delete();
    reset = 1'b1;
    @(negedge clk_16MHz);
    reset = 1'b0;
    modelReset();
    checkResetValues("midpix_reset");
    applyStimulus(1'b1, 8'h34);
    applyStimulus(1'b1, 8'h56);
    applyStimulus(1'b1, 8'h78);
    repeat (2) @(negedge clk_16MHz);
    checkOutput("idle_data_no_pix", 32'(pixQ.size()), 0);
`ifdef ILI9341_DEC_STATS_EN
    checkOutput("drop_count", 32'(drop_count), 3);
    checkOutput("pix_count", 32'(pix_count), 0);
    runPixels(2, "stats_pix");
    checkOutput("pix_count_after", 32'(pix_count), 2);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ili9341_bus_decoder.md
ILI9341_BUS_DECODER -- requirements
Module: ili9341_bus_decoder

Interface
REQ-001 Parameter COLS, default 320: panel columns (x range 0..COLS-1).
REQ-002 Parameter ROWS, default 240: panel pages (y range 0..ROWS-1).
REQ-003 The block SHALL have one clock, clk_16MHz; reset is asynchronous and active-high, port reset.
REQ-004 clk_16MHz  input  1  sole clock; all bus inputs are synchronous to it.
REQ-005 reset  input  1  async active-high reset.
REQ-006 nreset  input  1  panel hardware reset, active-low, sampled synchronously.
REQ-007 cmd_data  input  1  1 = data byte, 0 = command byte.
REQ-008 write_edge  input  1  write strobe; a byte is captured on its rising edge.
REQ-009 din  input  8  bus byte.
REQ-010 pix_valid  output  1  one-cycle pulse when a 16-bit pixel completes.
REQ-011 pix_x, pix_y  output  9 each  pixel address for the current pix_valid.
REQ-012 pix_data  output  16  pixel, first byte in [15:8].
REQ-013 display_on, sleep_out  output  1 each  panel status flags.
REQ-014 madctl, pixfmt  output  8 each  last accepted MADCTL (0x36) / COLMOD (0x3A) parameter.
REQ-015 win_err  output  1  one-cycle pulse when a CASET/PASET update is rejected.

Function
REQ-016 Byte capture SHALL occur on a cycle where write_edge=1 and registered write_edge (previous cycle)=0; write_edge held high SHALL capture only once.
REQ-017 FSM states SHALL be IDLE, CASET, PASET, RAMWR_HI, RAMWR_LO, PARAM1, SKIP.
REQ-018 A captured command byte SHALL abort any state and dispatch: 0x2A->CASET, 0x2B->PASET, 0x2C->RAMWR_HI with cursor (x,y)=(SC,SP), 0x36/0x3A->PARAM1, 0x01 soft reset->IDLE, 0x11 sleep_out=1, 0x10 sleep_out=0, 0x29 display_on=1, 0x28 display_on=0, all other codes->SKIP.
REQ-019 CASET/PASET SHALL collect exactly 4 data bytes (start MSB, start LSB, end MSB, end LSB), then return to IDLE; registers update atomically after the 4th byte only.
REQ-020 Window update SHALL be rejected (old values kept, win_err pulse next cycle) if start>end or end>=COLS (CASET) / end>=ROWS (PASET).
REQ-021 A command arriving before the 4th byte SHALL discard the partial CASET/PASET.
REQ-022 PARAM1 SHALL store the first data byte into madctl or pixfmt, then go to SKIP.
REQ-023 SKIP and IDLE SHALL ignore data bytes.
REQ-024 RAMWR_HI SHALL latch din as high byte; RAMWR_LO SHALL form the pixel and assert pix_valid, pix_x, pix_y, pix_data in the cycle after the low-byte capture (latency 1), then return to RAMWR_HI.
REQ-025 After each pixel: x<end col ->x+1; x==EC -> x=SC and y+1; x==EC and y==EP -> x=SC, y=SP (wrap).
REQ-026 Soft reset (0x01) and nreset=0 SHALL restore all reset values of REQ-028; captures while nreset=0 SHALL be ignored.
REQ-027 Pixels SHALL be emitted regardless of sleep_out/display_on.

Reset
REQ-028 On reset: FSM=IDLE, pix_valid=0, pix_x=pix_y=0, pix_data=0, display_on=0, sleep_out=0, madctl=0x00, pixfmt=0x66, win_err=0, SC=0, EC=COLS-1, SP=0, EP=ROWS-1, write_edge history=0.
REQ-029 Reset asserted mid-pixel SHALL discard the held high byte without emitting pix_valid.

Configuration
REQ-030 With ILI9341_DEC_STATS_EN defined: outputs pix_count (16) and drop_count (16), saturating; pix_count increments per pix_valid, drop_count per ignored data byte (IDLE/SKIP); both cleared by reset, soft reset, nreset. Without it: ports and counters absent.

Structure
REQ-031 Package ili9341_pkg SHALL hold command code constants, FSM state type, default COLS/ROWS.
REQ-032 Sub-module ili9341_window_ctr SHALL hold SC/EC/SP/EP and the x/y cursor with wrap logic.

Verification
REQ-033 Cmd 0x2A, data 00 0A 00 0B; cmd 0x2B, data 00 05 00 05; cmd 0x2C; 4 pixel pairs -> pixels at (10,5),(11,5),(10,5),(11,5) (wrap).
REQ-034 Cmd 0x2C, data 0xF8,0x1F -> pix_valid one cycle after 2nd capture, pix_data=0xF81F at (0,0).
REQ-035 Cmd 0x2A, data 00 10 00 05 -> win_err pulse; subsequent RAMWR pixels start at x=0, window 0..319 intact.
REQ-036 Cmd 0x2A, data 00 10, cmd 0x29 -> display_on=1, window unchanged; write_edge held high 5 cycles -> single capture.
REQ-037 Cmd 0x2C, one data byte, then reset pulse -> no pix_valid; all outputs at REQ-028 values; with ILI9341_DEC_STATS_EN, 3 data bytes in IDLE -> drop_count=3.
